// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory read port among NR channels and one write
// port among NW channels; read data is returned to the issuing channel after RD_LAT+1 cycles.
module mem_port_arbiter #(
    parameter int  NR             = 3,
    parameter int  NW             = 1,
    parameter int  AXI_WIDTH      = 128,
    parameter int  AXI_ADDR_WIDTH = 32,
    parameter int  LSB            = $clog2(AXI_WIDTH) - 3,
    parameter int  RD_LAT         = 1,
    localparam int AW             = AXI_ADDR_WIDTH - LSB,
    localparam int SW             = AXI_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NR-1:0]          rd_ren,
    input  logic [NR*AW-1:0]       rd_addr,
    output logic [NR-1:0]          rd_gnt,
    output logic [NR-1:0]          rd_valid,
    output logic [NR*AXI_WIDTH-1:0] rd_data,
    input  logic [NW-1:0]          wr_wen,
    input  logic [NW*AW-1:0]       wr_addr,
    input  logic [NW*AXI_WIDTH-1:0] wr_data,
    input  logic [NW*SW-1:0]       wr_strb,
    output logic [NW-1:0]          wr_gnt,
    output logic                   m_ren,
    output logic [AW-1:0]          m_raddr,
    input  logic [AXI_WIDTH-1:0]   m_rdata,
    output logic                   m_wen,
    output logic [AW-1:0]          m_waddr,
    output logic [AXI_WIDTH-1:0]   m_wdata,
    output logic [SW-1:0]          m_wstrb
);

    localparam int RIW = (NR > 1) ? $clog2(NR) : 1;
    localparam int WIW = (NW > 1) ? $clog2(NW) : 1;

    logic [RIW-1:0] r_rptr;
    logic [RIW-1:0] w_rptr_nxt;
    logic [RIW-1:0] w_rd_idx;
    logic           w_rd_any;
    logic [NR-1:0]  w_rd_gnt;

    logic [WIW-1:0] r_wptr;
    logic [WIW-1:0] w_wptr_nxt;
    logic [WIW-1:0] w_wr_idx;
    logic           w_wr_any;
    logic [NW-1:0]  w_wr_gnt;

    logic [RD_LAT-1:0]    r_pv;
    logic [RIW-1:0]       r_pid [RD_LAT];
    logic [NR-1:0]        w_ret_hit;
    logic [NR-1:0]        r_rd_valid;
    logic [NR*AXI_WIDTH-1:0] r_rd_data;

    // Read grant: first requester found searching upward from the pointer, wrapping.
    always_comb begin
        int j;
        logic hit;
        w_rd_gnt = '0;
        w_rd_idx = '0;
        w_rd_any = 1'b0;
        for (int k = 0; k < NR; k++) begin
            j = int'(r_rptr) + k;
            j = (j >= NR) ? (j - NR) : j;
            hit = !w_rd_any && rd_ren[j];
            w_rd_gnt[j] = hit;
            w_rd_idx = hit ? RIW'(j) : w_rd_idx;
            w_rd_any = w_rd_any | hit;
        end
        if (w_rd_any) begin
            w_rptr_nxt = (w_rd_idx == RIW'(NR - 1)) ? RIW'(0) : (w_rd_idx + RIW'(1));
        end else begin
            w_rptr_nxt = r_rptr;
        end
    end

    // Write grant: same rotating search over the write channels.
    always_comb begin
        int j;
        logic hit;
        w_wr_gnt = '0;
        w_wr_idx = '0;
        w_wr_any = 1'b0;
        for (int k = 0; k < NW; k++) begin
            j = int'(r_wptr) + k;
            j = (j >= NW) ? (j - NW) : j;
            hit = !w_wr_any && wr_wen[j];
            w_wr_gnt[j] = hit;
            w_wr_idx = hit ? WIW'(j) : w_wr_idx;
            w_wr_any = w_wr_any | hit;
        end
        if (w_wr_any) begin
            w_wptr_nxt = (w_wr_idx == WIW'(NW - 1)) ? WIW'(0) : (w_wr_idx + WIW'(1));
        end else begin
            w_wptr_nxt = r_wptr;
        end
    end

    // Round-robin pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rptr <= '0;
            r_wptr <= '0;
        end else begin
            r_rptr <= w_rptr_nxt;
            r_wptr <= w_wptr_nxt;
        end
    end

    // Return pipeline: tracks which channel owns each outstanding read, in issue order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pv <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pid[i] <= '0;
            end
        end else begin
            r_pv[0]  <= w_rd_any;
            r_pid[0] <= w_rd_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pv[i]  <= r_pv[i-1];
                r_pid[i] <= r_pid[i-1];
            end
        end
    end

    // Decode the pipeline tail into a per-channel capture strobe.
    always_comb begin
        w_ret_hit = '0;
        for (int c = 0; c < NR; c++) begin
            w_ret_hit[c] = r_pv[RD_LAT-1] && (r_pid[RD_LAT-1] == RIW'(c));
        end
    end

    // Per-channel data registers; only the returning channel is overwritten.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            for (int c = 0; c < NR; c++) begin
                r_rd_valid[c] <= w_ret_hit[c];
                if (w_ret_hit[c]) begin
                    r_rd_data[c*AXI_WIDTH +: AXI_WIDTH] <= m_rdata;
                end
            end
        end
    end

    assign rd_gnt   = w_rd_gnt;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign m_ren    = w_rd_any;
    assign m_raddr  = rd_addr[int'(w_rd_idx)*AW +: AW];

    // Zero-strobe writes still take their slot; the memory simply sees no byte enables.
    assign wr_gnt   = w_wr_gnt;
    assign m_wen    = w_wr_any;
    assign m_waddr  = wr_addr[int'(w_wr_idx)*AW +: AW];
    assign m_wdata  = wr_data[int'(w_wr_idx)*AXI_WIDTH +: AXI_WIDTH];
    assign m_wstrb  = wr_strb[int'(w_wr_idx)*SW +: SW];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance A (NR=3, NW=2, RD_LAT=2) and B (NR=3, NW=1, RD_LAT=3),
// each with a read-before-write memory model; returns are checked by a scoreboard.
module tb_mem_port_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int SW = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        int          ch;
        logic [DW-1:0] data;
        int          cyc;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    logic [2:0]      a_rd_ren, a_rd_gnt, a_rd_valid;
    logic [3*AW-1:0] a_rd_addr;
    logic [3*DW-1:0] a_rd_data;
    logic [1:0]      a_wr_wen, a_wr_gnt;
    logic [2*AW-1:0] a_wr_addr;
    logic [2*DW-1:0] a_wr_data;
    logic [2*SW-1:0] a_wr_strb;
    logic            a_m_ren, a_m_wen;
    logic [AW-1:0]   a_m_raddr, a_m_waddr;
    logic [DW-1:0]   a_m_rdata, a_m_wdata;
    logic [SW-1:0]   a_m_wstrb;

    logic [2:0]      b_rd_ren, b_rd_gnt, b_rd_valid;
    logic [3*AW-1:0] b_rd_addr;
    logic [3*DW-1:0] b_rd_data;
    logic [0:0]      b_wr_wen, b_wr_gnt;
    logic [AW-1:0]   b_wr_addr;
    logic [DW-1:0]   b_wr_data;
    logic [SW-1:0]   b_wr_strb;
    logic            b_m_ren, b_m_wen;
    logic [AW-1:0]   b_m_raddr, b_m_waddr;
    logic [DW-1:0]   b_m_rdata, b_m_wdata;
    logic [SW-1:0]   b_m_wstrb;

    mem_port_arbiter #(.NR(3), .NW(2), .AXI_WIDTH(DW), .AXI_ADDR_WIDTH(32), .RD_LAT(2)) dut_a (
        .clk(clk), .rstn(rstn),
        .rd_ren(a_rd_ren), .rd_addr(a_rd_addr), .rd_gnt(a_rd_gnt), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .wr_wen(a_wr_wen), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_strb(a_wr_strb), .wr_gnt(a_wr_gnt),
        .m_ren(a_m_ren), .m_raddr(a_m_raddr), .m_rdata(a_m_rdata),
        .m_wen(a_m_wen), .m_waddr(a_m_waddr), .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb)
    );

    mem_port_arbiter #(.NR(3), .NW(1), .AXI_WIDTH(DW), .AXI_ADDR_WIDTH(32), .RD_LAT(3)) dut_b (
        .clk(clk), .rstn(rstn),
        .rd_ren(b_rd_ren), .rd_addr(b_rd_addr), .rd_gnt(b_rd_gnt), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .wr_wen(b_wr_wen), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_strb(b_wr_strb), .wr_gnt(b_wr_gnt),
        .m_ren(b_m_ren), .m_raddr(b_m_raddr), .m_rdata(b_m_rdata),
        .m_wen(b_m_wen), .m_waddr(b_m_waddr), .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb)
    );

    // Memory models: read sees the value before a same-cycle write.
    logic [DW-1:0] mem_a [256];
    logic [DW-1:0] mem_b [256];
    logic [DW-1:0] a_rp [2];
    logic [DW-1:0] b_rp [3];

    always @(posedge clk) begin
        a_rp[0] <= mem_a[a_m_raddr[7:0]];
        a_rp[1] <= a_rp[0];
        if (a_m_wen)
            for (int i = 0; i < SW; i++)
                if (a_m_wstrb[i]) mem_a[a_m_waddr[7:0]][i*8 +: 8] <= a_m_wdata[i*8 +: 8];
    end
    assign a_m_rdata = a_rp[1];

    always @(posedge clk) begin
        b_rp[0] <= mem_b[b_m_raddr[7:0]];
        b_rp[1] <= b_rp[0];
        b_rp[2] <= b_rp[1];
        if (b_m_wen)
            for (int i = 0; i < SW; i++)
                if (b_m_wstrb[i]) mem_b[b_m_waddr[7:0]][i*8 +: 8] <= b_m_wdata[i*8 +: 8];
    end
    assign b_m_rdata = b_rp[2];

    task automatic chk(input string name, input logic [3*DW-1:0] act, input logic [3*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for A: pops one expectation per rd_valid pulse.
    initial begin
        exp_t e;
        logic [DW-1:0] sh [3];
        forever begin
            @(negedge clk);
            if (!rstn) begin
                for (int c = 0; c < 3; c++) sh[c] = '0;
            end else begin
                for (int c = 0; c < 3; c++) begin
                    if (a_rd_valid[c]) begin
                        if (q_a.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL a_unexpected_valid: channel %0d pulsed at cycle %0d, required no pulse", c, cyc);
                        end else begin
                            e = q_a.pop_front();
                            chk("a_ret_channel", c, e.ch);
                            chk("a_ret_cycle", cyc, e.cyc);
                            sh[e.ch] = e.data;
                            chk("a_rd_data", a_rd_data, {sh[2], sh[1], sh[0]});
                        end
                    end
                end
            end
        end
    end

    // Scoreboard monitor for B.
    initial begin
        exp_t e;
        logic [DW-1:0] sh [3];
        forever begin
            @(negedge clk);
            if (!rstn) begin
                for (int c = 0; c < 3; c++) sh[c] = '0;
            end else begin
                for (int c = 0; c < 3; c++) begin
                    if (b_rd_valid[c]) begin
                        if (q_b.size() == 0) begin
                            n_checks++; n_fail++;
                            $display("FAIL b_unexpected_valid: channel %0d pulsed at cycle %0d, required no pulse", c, cyc);
                        end else begin
                            e = q_b.pop_front();
                            chk("b_ret_channel", c, e.ch);
                            chk("b_ret_cycle", cyc, e.cyc);
                            sh[e.ch] = e.data;
                            chk("b_rd_data", b_rd_data, {sh[2], sh[1], sh[0]});
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: still running at cycle %0d, required finish well before that", cyc);
        $fatal(1);
    end

    task automatic a_wr1(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(posedge clk); #1;
        a_wr_wen = 2'b10;
        a_wr_addr[AW +: AW] = addr;
        a_wr_data[DW +: DW] = data;
        a_wr_strb[SW +: SW] = 16'hFFFF;
        @(negedge clk); chk("a_preload_wgnt", a_wr_gnt, 2'b10);
        @(posedge clk); #1 a_wr_wen = 2'b00;
    endtask

    task automatic b_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(posedge clk); #1;
        b_wr_wen = 1'b1; b_wr_addr = addr; b_wr_data = data; b_wr_strb = 16'hFFFF;
        @(negedge clk); chk("b_nw1_wgnt", b_wr_gnt, 1'b1);
        @(posedge clk); #1 b_wr_wen = 1'b0;
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic a_issue(input logic [2:0] ren, input int ch, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input bit track);
        exp_t e;
        a_rd_ren = ren;
        @(negedge clk);
        chk("a_rd_gnt", a_rd_gnt, 3'b001 << ch);
        chk("a_m_raddr", a_m_raddr, addr);
        chk("a_m_ren", a_m_ren, 1'b1);
        e.ch = ch; e.data = data; e.cyc = cyc + 3;
        if (track) q_a.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic b_issue(input logic [2:0] ren, input int ch, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data);
        exp_t e;
        b_rd_ren = ren;
        @(negedge clk);
        chk("b_rd_gnt", b_rd_gnt, 3'b001 << ch);
        chk("b_m_raddr", b_m_raddr, addr);
        e.ch = ch; e.data = data; e.cyc = cyc + 4;
        q_b.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_pending", q_a.size() + q_b.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int pulses;
        a_rd_ren = '0; a_rd_addr = '0; a_wr_wen = '0; a_wr_addr = '0; a_wr_data = '0; a_wr_strb = '0;
        b_rd_ren = '0; b_rd_addr = '0; b_wr_wen = '0; b_wr_addr = '0; b_wr_data = '0; b_wr_strb = '0;

        repeat (2) @(negedge clk);
        chk("rst_a_rd_valid", a_rd_valid, 3'b000);
        chk("rst_a_rd_data", a_rd_data, '0);
        chk("rst_a_m_ren", a_m_ren, 1'b0);
        chk("rst_a_m_wen", a_m_wen, 1'b0);
        chk("rst_a_gnts", {a_rd_gnt, a_wr_gnt}, 5'b0);
        chk("rst_b_rd_valid", b_rd_valid, 3'b000);
        @(posedge clk); #1 rstn = 1'b1;

        a_wr1(28'h10, {16{8'hA5}});
        a_wr1(28'h20, 128'h1);
        a_wr1(28'h30, 128'hC0);
        a_wr1(28'h31, 128'hC1);
        a_wr1(28'h32, 128'hC2);
        a_wr1(28'h40, {16{8'h55}});
        b_wr(28'h4, 128'hB4);
        b_wr(28'h8, 128'hB8);
        b_wr(28'hC, 128'hBC);

        // Back-to-back reads on B, RD_LAT=3: returns in consecutive cycles to 2,0,2.
        @(posedge clk); #1;
        b_rd_addr[2*AW +: AW] = 28'h4;
        b_issue(3'b100, 2, 28'h4, 128'hB4);
        b_rd_addr[0 +: AW] = 28'h8;
        b_issue(3'b001, 0, 28'h8, 128'hB8);
        b_rd_addr[2*AW +: AW] = 28'hC;
        b_issue(3'b100, 2, 28'hC, 128'hBC);
        b_rd_ren = 3'b000;
        drain();

        // Single read on channel 1; other channels' data must stay zero.
        a_rd_addr[AW +: AW] = 28'h10;
        a_issue(3'b010, 1, 28'h10, {16{8'hA5}}, 1'b1);
        a_rd_ren = 3'b000;
        drain();

        // Channel 2 read moves the pointer back to 0 ahead of the contention run.
        a_rd_addr[2*AW +: AW] = 28'h32;
        a_issue(3'b100, 2, 28'h32, 128'hC2, 1'b1);
        a_rd_addr = {28'h32, 28'h31, 28'h30};
        for (int k = 0; k < 9; k++)
            a_issue(3'b111, k % 3, 28'h30 + 28'(k % 3), 128'hC0 + 128'(k % 3), 1'b1);
        a_rd_ren = 3'b000;
        drain();

        // Two writers: ch0 writes low 8 bytes first, ch1's zero-strobe write follows.
        a_wr_wen = 2'b11;
        a_wr_addr = {28'h40, 28'h40};
        a_wr_data = {{DW{1'b1}}, {DW{1'b1}}};
        a_wr_strb = {16'h0000, 16'h00FF};
        @(negedge clk);
        chk("a_w0_gnt", a_wr_gnt, 2'b01);
        chk("a_w0_strb", a_m_wstrb, 16'h00FF);
        chk("a_w0_addr", a_m_waddr, 28'h40);
        chk("a_w0_wen", a_m_wen, 1'b1);
        @(posedge clk); #1 a_wr_wen = 2'b10;
        @(negedge clk);
        chk("a_w1_gnt", a_wr_gnt, 2'b10);
        chk("a_w1_wen", a_m_wen, 1'b1);
        chk("a_w1_strb", a_m_wstrb, 16'h0000);
        @(posedge clk); #1 a_wr_wen = 2'b00;
        a_rd_addr[0 +: AW] = 28'h40;
        a_issue(3'b001, 0, 28'h40, {{8{8'h55}}, {8{8'hFF}}}, 1'b1);

        // Same-cycle read and write to 0x20: read returns the old value.
        begin
            exp_t e;
            a_rd_addr[0 +: AW] = 28'h20;
            a_wr_addr[0 +: AW] = 28'h20;
            a_wr_data[0 +: DW] = 128'h2;
            a_wr_strb[0 +: SW] = 16'hFFFF;
            a_wr_wen = 2'b01;
            a_rd_ren = 3'b001;
            @(negedge clk);
            chk("a_rw_rgnt", a_rd_gnt, 3'b001);
            chk("a_rw_wgnt", a_wr_gnt, 2'b01);
            e.ch = 0; e.data = 128'h1; e.cyc = cyc + 3;
            q_a.push_back(e);
            @(posedge clk); #1;
            a_wr_wen = 2'b00;
            a_rd_ren = 3'b000;
        end
        @(posedge clk); #1;
        a_issue(3'b001, 0, 28'h20, 128'h2, 1'b1);
        a_rd_ren = 3'b000;
        drain();

        // Reset one cycle after a read issues: that read must never return.
        a_rd_addr[0 +: AW] = 28'h10;
        a_issue(3'b001, 0, 28'h10, '0, 1'b0);
        a_rd_ren = 3'b000;
        rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_rd_valid != 3'b000) pulses++;
        end
        chk("a_rst_dropped_reads", pulses, 0);
        chk("a_rst_rd_data", a_rd_data, '0);
        @(posedge clk); #1;
        a_rd_addr = {28'h32, 28'h31, 28'h30};
        a_issue(3'b111, 0, 28'h30, 128'hC0, 1'b1);
        a_rd_ren = 3'b000;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
